// File: rtl/hc595_frame_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hc595_frame_serializer
//
// Shifts one parallel frame word into a chain of 74HC595 devices and then
// pulses the storage latch. It sits after the 7-segment digit/colon encoder:
// every refresh the encoder presents a pattern and pulses trigger_i, and this
// block clocks the pattern out MSB first and reports busy/done so the digit
// scanner knows when it can move on.
//
// Parameters
//   NUM_ICS  number of chained 595s; frame width N = 8*NUM_ICS
//   CLK_DIV  clk_i cycles per SCLK half-period and per latch pulse (1..255)
//
// Ports
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   trigger_i   start request, only looked at while idle
//   data_i      frame word; bit N-1 goes out first and ends in the last QH
//   busy_o      high while a frame is in progress (including the done cycle)
//   done_o      one-cycle pulse after the latch pulse ends
//   sclk_o      595 SRCLK
//   data_o      595 SER
//   latch_en_o  595 RCLK
//   oe_n_o      595 OE (only with HC595_BLANK_EN defined)
//
// Build option
//   HC595_BLANK_EN  adds oe_n_o, which holds the display blanked from reset
//                   until the first complete frame has been latched.
//
// Every output comes straight from a flop; nothing from the inputs reaches
// the outputs combinationally.
// -----------------------------------------------------------------------------
module hc595_frame_serializer #(
  parameter int NUM_ICS = 2,
  parameter int CLK_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trigger_i,
  input  logic [8*NUM_ICS-1:0] data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sclk_o,
  output logic                 data_o,
  output logic                 latch_en_o
`ifdef HC595_BLANK_EN
  ,
  output logic                 oe_n_o
`endif
);

  localparam int N  = 8 * NUM_ICS;
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(N);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t        state_q;
  // Only the bits still to be sent are kept; the MSB goes to data_o directly
  // at capture, so the register is one bit narrower than the frame.
  logic [N-2:0]  shreg_q;
  logic [BW-1:0] bitcnt_q;
  logic [BW-1:0] bitcnt_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          phase_last;
  logic          sclk_q;
  logic          data_q;
  logic          latch_q;
  logic          busy_q;
  logic          done_q;
`ifdef HC595_BLANK_EN
  logic          oe_n_q;
`endif

  // The phase counter times every D-cycle interval (SCLK low, SCLK high,
  // latch) and wraps back to zero on the last cycle of each interval, so a
  // new interval always starts from zero.
  always_comb begin
    phase_last = (phase_q == PH_LAST);
    phase_d    = phase_last ? '0 : phase_q + PW'(1);
    bitcnt_d   = bitcnt_q - BW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      phase_q  <= '0;
      sclk_q   <= 1'b0;
      data_q   <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef HC595_BLANK_EN
      oe_n_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_i) begin
            shreg_q  <= data_i[N-2:0];
            data_q   <= data_i[N-1];
            bitcnt_q <= BIT_LAST;
            phase_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          phase_q <= phase_d;
          if (phase_last) begin
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          phase_q <= phase_d;
          if (phase_last) begin
            sclk_q <= 1'b0;
            if (bitcnt_q == '0) begin
              // Last bit clocked: SCLK drops and RCLK rises on the same edge,
              // so the two are never high together.
              latch_q <= 1'b1;
              state_q <= LATCH;
            end else begin
              // New data changes on the falling SCLK edge, giving D cycles of
              // hold after the rise and D cycles of setup before the next one.
              bitcnt_q <= bitcnt_d;
              data_q   <= shreg_q[N-2];
              shreg_q  <= {shreg_q[N-3:0], 1'b0};
              state_q  <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          phase_q <= phase_d;
          if (phase_last) begin
            latch_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef HC595_BLANK_EN
            oe_n_q  <= 1'b0;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          data_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sclk_o     = sclk_q;
  assign data_o     = data_q;
  assign latch_en_o = latch_q;
`ifdef HC595_BLANK_EN
  assign oe_n_o     = oe_n_q;
`endif

endmodule

// File: tb/tb_hc595_frame_serializer.sv
`timescale 1ns/1ps
// Directed bench for hc595_frame_serializer: one instance with D = 1 and one
// with D = 3, both with two chained 595s (16-bit frames).
module tb_hc595_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: CLK_DIV = 1
  logic        rst, trig, busy, done, sclk, sdat, latch;
  logic [15:0] din;
  // DUT B: CLK_DIV = 3
  logic        rst_b, trig_b, busy_b, done_b, sclk_b, sdat_b, latch_b;
  logic [15:0] din_b;
`ifdef HC595_BLANK_EN
  logic        oe_n, oe_n_b;
`endif

  hc595_frame_serializer #(.NUM_ICS(2), .CLK_DIV(1)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .trigger_i  (trig),
    .data_i     (din),
    .busy_o     (busy),
    .done_o     (done),
    .sclk_o     (sclk),
    .data_o     (sdat),
    .latch_en_o (latch)
`ifdef HC595_BLANK_EN
    ,
    .oe_n_o     (oe_n)
`endif
  );

  hc595_frame_serializer #(.NUM_ICS(2), .CLK_DIV(3)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst_b),
    .trigger_i  (trig_b),
    .data_i     (din_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .sclk_o     (sclk_b),
    .data_o     (sdat_b),
    .latch_en_o (latch_b)
`ifdef HC595_BLANK_EN
    ,
    .oe_n_o     (oe_n_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer for DUT A, sampled on the falling edge (outputs move on rising).
  logic        sclk_pv = 1'b0, latch_pv = 1'b0, busy_pv = 1'b0;
  logic [15:0] word_a = '0, q595 = '0, din_pv = '0;
  int          rises_a = 0, latch_cyc_a = 0, latch_pulses_a = 0;
  int          done_a = 0, overlap_a = 0, busy_cyc_a = 0;
  int          start_cyc[$];
  logic [15:0] start_exp[$];
  logic [15:0] frame_words[$];

  always @(negedge clk) begin
    if (sclk && !sclk_pv) begin
      rises_a <= rises_a + 1;
      word_a  <= {word_a[14:0], sdat};
    end
    if (latch && !latch_pv) begin
      latch_pulses_a <= latch_pulses_a + 1;
      q595           <= word_a;
    end
    if (latch)         latch_cyc_a <= latch_cyc_a + 1;
    if (latch && sclk) overlap_a   <= overlap_a + 1;
    if (busy)          busy_cyc_a  <= busy_cyc_a + 1;
    if (busy && !busy_pv) begin
      start_cyc.push_back(cyc);
      start_exp.push_back(din_pv);
    end
    if (done) begin
      done_a <= done_a + 1;
      frame_words.push_back(word_a);
    end
    sclk_pv  <= sclk;
    latch_pv <= latch;
    busy_pv  <= busy;
    din_pv   <= din;
  end

  // Observer for DUT B: bit capture plus run lengths of SCLK phases.
  logic        sclkb_pv = 1'b0;
  logic [15:0] word_b = '0;
  int          rises_b = 0, latch_cyc_b = 0, hi_run = 0, lo_run = 0;
  int          hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;

  always @(negedge clk) begin
    if (sclk_b && !sclkb_pv) begin
      rises_b <= rises_b + 1;
      word_b  <= {word_b[14:0], sdat_b};
    end
    if (latch_b) latch_cyc_b <= latch_cyc_b + 1;
    if (sclk_b) begin
      hi_run <= hi_run + 1;
    end else if (hi_run != 0) begin
      if (hi_run < hi_min) hi_min <= hi_run;
      if (hi_run > hi_max) hi_max <= hi_run;
      hi_run <= 0;
    end
    if (busy_b && !sclk_b && !latch_b && !done_b) begin
      lo_run <= lo_run + 1;
    end else if (lo_run != 0) begin
      if (lo_run < lo_min) lo_min <= lo_run;
      if (lo_run > lo_max) lo_max <= lo_run;
      lo_run <= 0;
    end
    sclkb_pv <= sclk_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, l0, lp0, d0, f0, s0;
    logic ok;
    logic oe_at_latch;
    rst = 1'b1; trig = 1'b0; din = '0;
    rst_b = 1'b1; trig_b = 1'b0; din_b = '0;
    oe_at_latch = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_data", sdat, 0);
    chk("rst_latch", latch, 0);
`ifdef HC595_BLANK_EN
    chk("rst_oe_n", oe_n, 1);
`endif
    rst = 1'b0; rst_b = 1'b0;
    repeat (10) tick();
    chk("idle_busy_cycles", busy_cyc_a, 0);
    chk("idle_rises", rises_a, 0);

    // Single frame 16'hA53C, second trigger while busy must be ignored
    r0 = rises_a; l0 = latch_cyc_a; lp0 = latch_pulses_a; d0 = done_a;
    din = 16'hA53C; trig = 1'b1; t0 = cyc;
    tick();
    trig = 1'b0; din = 16'h0000;
    repeat (5) tick();
    chk("mid_busy", busy, 1);
`ifdef HC595_BLANK_EN
    chk("oe_n_mid_first", oe_n, 1);
`endif
    trig = 1'b1;
    tick();
    trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
`ifdef HC595_BLANK_EN
      if (latch) oe_at_latch = oe_n;
`endif
      if (done) begin ok = 1'b1; break; end
    end
    chk("frame_done_seen", ok, 1);
    chk("done_latency", cyc - t0, 34);
`ifdef HC595_BLANK_EN
    chk("oe_n_during_latch", oe_at_latch, 1);
    chk("oe_n_after_latch", oe_n, 0);
`endif
    repeat (10) tick();
    chk("frame_rises", rises_a - r0, 16);
    chk("frame_word", word_a, 16'hA53C);
    chk("latch_cycles", latch_cyc_a - l0, 1);
    chk("latch_pulses", latch_pulses_a - lp0, 1);
    chk("ic_far_A5", q595[15:8], 8'hA5);
    chk("ic_near_3C", q595[7:0], 8'h3C);
    chk("done_pulses", done_a - d0, 1);
    chk("idle_after_busy", busy, 0);
    chk("idle_after_data", sdat, 0);
    chk("latch_sclk_overlap", overlap_a, 0);

    // Continuous refresh: trigger held, data changing every cycle
    s0 = start_cyc.size(); f0 = frame_words.size(); d0 = done_a;
    din = 16'h1357; trig = 1'b1;
    for (int i = 0; i < 200 && (done_a - d0) < 3; i++) begin
      tick();
      din = din + 16'h3B47;
      if ((done_a - d0) >= 3) trig = 1'b0;
    end
    trig = 1'b0;
    repeat (5) tick();
    chk("cont_frames", frame_words.size() - f0, 3);
    chk("cont_starts", start_cyc.size() - s0, 3);
    if (frame_words.size() >= f0 + 3 && start_cyc.size() >= s0 + 3) begin
      chk("cont_word0", frame_words[f0], 16'h1357);
      chk("cont_word1", frame_words[f0 + 1], 16'h2E0C);
      chk("cont_word2", frame_words[f0 + 2], start_exp[s0 + 2]);
      chk("cont_period01", start_cyc[s0 + 1] - start_cyc[s0], 35);
      chk("cont_period12", start_cyc[s0 + 2] - start_cyc[s0 + 1], 35);
    end
    chk("cont_overlap", overlap_a, 0);

    // Reset after the 7th rising SCLK edge
    lp0 = latch_pulses_a; r0 = rises_a;
    din = 16'hC3A5; trig = 1'b1;
    tick();
    trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rises_a - r0 >= 7) begin ok = 1'b1; break; end
    end
    chk("midrst_7_rises", ok, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sclk", sclk, 0);
    chk("midrst_data", sdat, 0);
    chk("midrst_latch", latch, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
`ifdef HC595_BLANK_EN
    chk("midrst_oe_n", oe_n, 1);
`endif
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_latch", latch_pulses_a - lp0, 0);
    chk("midrst_stay_idle", busy, 0);

    r0 = rises_a; lp0 = latch_pulses_a;
    din = 16'h5AC3; trig = 1'b1;
    tick();
    trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("clean_done_seen", ok, 1);
    repeat (3) tick();
    chk("clean_rises", rises_a - r0, 16);
    chk("clean_word", word_a, 16'h5AC3);
    chk("clean_latched", q595, 16'h5AC3);
    chk("clean_latch_pulses", latch_pulses_a - lp0, 1);
`ifdef HC595_BLANK_EN
    chk("clean_oe_n", oe_n, 0);
`endif

    // Divider D = 3 on DUT B
    din_b = 16'h0001; trig_b = 1'b1; t0 = cyc;
    tick();
    trig_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    chk("div_done_seen", ok, 1);
    chk("div_latency", cyc - t0, 100);
    repeat (3) tick();
    chk("div_rises", rises_b, 16);
    chk("div_word", word_b, 16'h0001);
    chk("div_hi_min", hi_min, 3);
    chk("div_hi_max", hi_max, 3);
    chk("div_lo_min", lo_min, 3);
    chk("div_lo_max", lo_max, 3);
    chk("div_latch_cycles", latch_cyc_b, 3);
    chk("div_idle_data", sdat_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
